coin_acceptor: RTL and testbench

COIN_ACCEPTOR -- requirements
Module: coin_acceptor

---
 rtl/coin_acceptor.sv | 83 ++++++++
 tb/tb_coin_acceptor.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/coin_acceptor.sv
// coin_acceptor: debounced two-slot coin sensor feeding a queued, rate-limited pulse output
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin5_raw,
  input  logic       coin10_raw,
  input  logic       enable,
  output logic       five_rup,
  output logic       ten_rup,
  output logic       coin_reject,
  output logic       busy,
  output logic [7:0] accepted_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;
  state_t state, state_n;
  logic [1:0] s1, s2, lvl, lvl_d, ev;
  logic [3:0] cnt [2];
  logic [FIFO_DEPTH-1:0] mem;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count, count_n;
  logic push, pop, reject, full;
  // two-flop synchronizers, debounced levels and their run-length counters (bit 0 = 5, bit 1 = 10)
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      lvl <= '0;
      lvl_d <= '0;
      cnt <= '{default: '0};
    end else begin
      s1 <= {coin10_raw, coin5_raw};
      s2 <= s1;
      lvl_d <= lvl;
      for (int c = 0; c < 2; c++)
        if (s2[c] == lvl[c]) cnt[c] <= '0;
        else if (cnt[c] == 4'(DEBOUNCE_CYCLES - 1)) begin
          lvl[c] <= s2[c];
          cnt[c] <= '0;
        end else cnt[c] <= cnt[c] + 4'd1;
    end
  end
  // accept/reject decision on debounced rising edges; full is judged before any same-cycle pop
  always_comb begin
    ev = lvl & ~lvl_d;
    full = count == (AW+1)'(FIFO_DEPTH);
    push = (ev == 2'b01 || ev == 2'b10) && enable && !full;
    reject = |ev && !push;
    pop = state == IDLE && count != '0;
    state_n = state == IDLE ? (pop ? PULSE : IDLE) : state == PULSE ? GAP : IDLE;
    count_n = count + (AW+1)'(push) - (AW+1)'(pop);
  end
  // coin queue, output FSM and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      accepted_cnt <= '0;
      five_rup <= 1'b0;
      ten_rup <= 1'b0;
      coin_reject <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      if (push) begin
        mem[wr_ptr] <= ev[1];
        wr_ptr <= wr_ptr + AW'(1);
        accepted_cnt <= accepted_cnt + 8'd1;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      five_rup <= pop && !mem[rd_ptr];
      ten_rup <= pop && mem[rd_ptr];
      coin_reject <= reject;
      busy <= count_n != '0 || state_n != IDLE;
    end
  end
endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: random and directed stimulus on two configurations, scoreboarded against a rule-level model
module tb_coin_acceptor;
  localparam int FD = 4;
  logic clk = 0, rst = 1, coin5_raw = 0, coin10_raw = 0, enable = 1;
  logic f0, f1, t0, t1, r0, r1, b0, b1;
  logic [7:0] a0, a1;
  int total = 0, bad = 0, cyc = 0;
  bit chk = 0;
  int dv [2] = '{4, 2};
  bit h1 [2][2], h2 [2][2], lv [2][2], ev [2][2];
  int run [2][2];
  bit fq [2][$];
  int tmr [2];
  logic [7:0] macc [2];
  int ep [2][$], er [2][$];
  int msz, me;
  bit mx, din, mf, mt, mr, mb;
  logic [7:0] ma;

  always #5 clk = ~clk;

  coin_acceptor #(.DEBOUNCE_CYCLES(4), .FIFO_DEPTH(FD)) u0 (.clk(clk), .rst(rst), .coin5_raw(coin5_raw),
    .coin10_raw(coin10_raw), .enable(enable), .five_rup(f0), .ten_rup(t0), .coin_reject(r0), .busy(b0), .accepted_cnt(a0));
  coin_acceptor #(.DEBOUNCE_CYCLES(2), .FIFO_DEPTH(FD)) u1 (.clk(clk), .rst(rst), .coin5_raw(coin5_raw),
    .coin10_raw(coin10_raw), .enable(enable), .five_rup(f1), .ten_rup(t1), .coin_reject(r1), .busy(b1), .accepted_cnt(a1));

  // reference model: level flips after D consecutive differing synchronized samples; queue of coins; one pulse per 3 cycles
  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        for (int c = 0; c < 2; c++) begin
          h1[i][c] = 0; h2[i][c] = 0; lv[i][c] = 0; ev[i][c] = 0; run[i][c] = 0;
        end
        fq[i].delete(); ep[i].delete(); er[i].delete();
        tmr[i] = 0; macc[i] = 0;
      end else begin
        msz = fq[i].size();
        if (tmr[i] > 0) tmr[i]--;
        else if (msz > 0) begin
          mx = fq[i].pop_front();
          ep[i].push_back(cyc * 2 + int'(mx));
          tmr[i] = 2;
        end
        if (ev[i][0] || ev[i][1]) begin
          if (ev[i][0] != ev[i][1] && enable && msz < FD) begin
            fq[i].push_back(ev[i][1]);
            macc[i] = macc[i] + 8'd1;
          end else er[i].push_back(cyc);
        end
        for (int c = 0; c < 2; c++) begin
          ev[i][c] = 0;
          din = h2[i][c];
          h2[i][c] = h1[i][c];
          h1[i][c] = c == 1 ? coin10_raw : coin5_raw;
          if (din != lv[i][c]) run[i][c]++;
          else run[i][c] = 0;
          if (run[i][c] == dv[i]) begin
            lv[i][c] = din;
            run[i][c] = 0;
            ev[i][c] = din;
          end
        end
      end
    end
  end

  // monitor: pops expected pulses/rejects when the DUT presents them and checks busy/accepted_cnt every cycle
  always @(negedge clk) if (chk) begin
    for (int i = 0; i < 2; i++) begin
      mf = i == 1 ? f1 : f0;
      mt = i == 1 ? t1 : t0;
      mr = i == 1 ? r1 : r0;
      mb = i == 1 ? b1 : b0;
      ma = i == 1 ? a1 : a0;
      while (ep[i].size() > 0 && ep[i][0] / 2 < cyc) begin
        total++; bad++;
        me = ep[i].pop_front();
        $display("FAIL missed_pulse[%0d] got none, want %s at cyc %0d", i, me % 2 == 1 ? "ten" : "five", me / 2);
      end
      while (er[i].size() > 0 && er[i][0] < cyc) begin
        total++; bad++;
        me = er[i].pop_front();
        $display("FAIL missed_reject[%0d] got none, want reject at cyc %0d", i, me);
      end
      total++;
      if (mf && mt) begin
        bad++;
        $display("FAIL both_pulses[%0d] got five=1 ten=1, want at most one", i);
      end
      if (mf || mt) begin
        total++;
        if (ep[i].size() == 0) begin
          bad++;
          $display("FAIL pulse[%0d] got five=%0b ten=%0b at cyc %0d, want no pulse", i, mf, mt, cyc);
        end else begin
          me = ep[i].pop_front();
          if (me != cyc * 2 + int'(mt)) begin
            bad++;
            $display("FAIL pulse[%0d] got %s at cyc %0d, want %s at cyc %0d", i, mt ? "ten" : "five", cyc,
              me % 2 == 1 ? "ten" : "five", me / 2);
          end
        end
      end
      if (mr) begin
        total++;
        if (er[i].size() == 0) begin
          bad++;
          $display("FAIL reject[%0d] got reject at cyc %0d, want none", i, cyc);
        end else begin
          me = er[i].pop_front();
          if (me != cyc) begin
            bad++;
            $display("FAIL reject[%0d] got reject at cyc %0d, want at cyc %0d", i, cyc, me);
          end
        end
      end
      total++;
      if (mb !== (fq[i].size() > 0 || tmr[i] > 0)) begin
        bad++;
        $display("FAIL busy[%0d] got %0b, want %0b at cyc %0d", i, mb, fq[i].size() > 0 || tmr[i] > 0, cyc);
      end
      total++;
      if (ma !== macc[i]) begin
        bad++;
        $display("FAIL accepted_cnt[%0d] got %0d, want %0d at cyc %0d", i, ma, macc[i], cyc);
      end
    end
  end

  task automatic drive(input bit a, input bit b, input int n);
    coin5_raw = a;
    coin10_raw = b;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    total++;
    if ({f0, t0, r0, b0, a0, f1, t1, r1, b1, a1} !== '0) begin
      bad++;
      $display("FAIL reset_state got %b, want all zero", {f0, t0, r0, b0, a0, f1, t1, r1, b1, a1});
    end
    chk = 1;
    rst = 0;
    drive(1, 0, 16); drive(0, 0, 16);
    repeat (3) begin drive(0, 1, 2); drive(0, 0, 1); end
    drive(0, 1, 16); drive(0, 0, 16);
    drive(1, 1, 16); drive(0, 0, 16);
    enable = 0; drive(1, 0, 16); drive(0, 0, 16);
    enable = 1; drive(1, 0, 16); drive(0, 0, 16);
    repeat (12) begin drive(1, 0, 2); drive(0, 1, 2); end
    drive(0, 0, 30);
    repeat (6) begin drive(1, 0, 2); drive(0, 1, 2); end
    coin5_raw = 0; coin10_raw = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    total++;
    if ({b1, a1, b0, a0} !== '0) begin
      bad++;
      $display("FAIL mid_reset got busy1=%0b acc1=%0d busy0=%0b acc0=%0d, want all zero", b1, a1, b0, a0);
    end
    drive(0, 0, 20);
    repeat (600) begin
      if ($urandom_range(0, 4) == 0) coin5_raw = ~coin5_raw;
      if ($urandom_range(0, 4) == 0) coin10_raw = ~coin10_raw;
      enable = $urandom_range(0, 7) != 0;
      rst = $urandom_range(0, 249) == 0;
      @(negedge clk);
    end
    rst = 0; enable = 1;
    drive(0, 0, 40);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (ep[i].size() != 0 || er[i].size() != 0) begin
        bad++;
        $display("FAIL drain[%0d] got %0d pulses and %0d rejects outstanding, want 0", i, ep[i].size(), er[i].size());
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
